fetch_queue: RTL and testbench

- Decoupling instruction queue directly downstream of the PC/fetch stage and upstream of decode.
- Accepts fetched packets (pc, inst, epoch, prediction), discards wrong-path packets whose epoch is stale, and presents in-order packets to decode with a valid/ready handshake.
- Tracks the fetch epoch locally and flushes all buffered entries on redirect.

---
 rtl/fetch_pkg.sv | 16 +
 rtl/fetchq_storage.sv | 32 +++
 rtl/fetch_queue.sv | 141 ++++++++++++++
 tb/tb_fetch_queue.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared widths and the fetch packet type for the fetch queue
// Contents: XLEN, EPOCH_W, fetch_pkt_t {pc, inst, epoch, pred_taken, pred_target}.
package fetch_pkg;

    localparam int XLEN    = 32;
    localparam int EPOCH_W = 3;

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [XLEN-1:0]    inst;
        logic [EPOCH_W-1:0] epoch;
        logic               pred_taken;
        logic [XLEN-1:0]    pred_target;
    } fetch_pkt_t;

endpackage

// File: rtl/fetchq_storage.sv
// rtl/fetchq_storage.sv - DEPTH-entry packet array, one write port, async read
// Ports: clk, rst (sync, active-high, clears all entries), wr_en/wr_addr/wr_data
// write port at the queue tail, rd_addr/rd_data combinational read at the head.
module fetchq_storage
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  fetch_pkt_t               wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output fetch_pkt_t               rd_data
);

    fetch_pkt_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - epoch-filtering decoupling queue between fetch and decode
// Ports: clk, rst (sync, active-high); in_* fetch packet with in_valid/in_ready;
// redirect_valid flush pulse; dec_* head packet with dec_valid/dec_ready;
// occupancy (registered entry count); drop_count (saturating stale-drop count).
// Optional: define FETCHQ_BYPASS_EN to pass a packet straight to decode when the
// queue is empty and decode is ready in the same cycle.
module fetch_queue #(
    parameter int DEPTH      = 4,
    parameter int EPOCH_W    = fetch_pkg::EPOCH_W,
    parameter int DROP_CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_pc,
    input  logic [31:0]              in_inst,
    input  logic [EPOCH_W-1:0]       in_epoch,
    input  logic                     in_pred_taken,
    input  logic [31:0]              in_pred_target,
    input  logic                     redirect_valid,
    output logic                     dec_valid,
    input  logic                     dec_ready,
    output logic [31:0]              dec_pc,
    output logic [31:0]              dec_inst,
    output logic [EPOCH_W-1:0]       dec_epoch,
    output logic                     dec_pred_taken,
    output logic [31:0]              dec_pred_target,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic [DROP_CNT_W-1:0]    drop_count
);

    import fetch_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]         head;
    logic [AW-1:0]         tail;
    logic [CW-1:0]         count;
    logic [EPOCH_W-1:0]    cur_epoch;
    logic [DROP_CNT_W-1:0] drop_cnt;

    fetch_pkt_t in_pkt;
    fetch_pkt_t head_pkt;
    fetch_pkt_t dec_pkt;

    logic stale;
    logic empty;
    logic full;
    logic bypass;
    logic push;
    logic drop;
    logic pop;

    assign in_pkt = '{pc: in_pc, inst: in_inst, epoch: in_epoch,
                      pred_taken: in_pred_taken, pred_target: in_pred_target};

    assign stale = in_valid && (in_epoch != cur_epoch);
    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

    // Stale and redirect-cycle packets are always swallowed, so they never
    // wait on space. A pop does not open a slot in the same cycle.
    assign in_ready = !rst && (redirect_valid || stale || !full);

`ifdef FETCHQ_BYPASS_EN
    assign bypass = !rst && empty && !redirect_valid && in_valid && !stale && dec_ready;
`else
    assign bypass = 1'b0;
`endif

    assign push      = in_valid && in_ready && !stale && !redirect_valid && !bypass;
    assign drop      = in_valid && in_ready && (stale || redirect_valid);
    assign dec_valid = !rst && ((!empty && !redirect_valid) || bypass);
    assign pop       = dec_valid && dec_ready && !empty;

    fetchq_storage #(.DEPTH(DEPTH)) u_storage (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push),
        .wr_addr (tail),
        .wr_data (in_pkt),
        .rd_addr (head),
        .rd_data (head_pkt)
    );

    always_comb begin
        dec_pkt = '0;
        if (!rst) begin
            if (!empty) begin
                dec_pkt = head_pkt;
            end else if (bypass) begin
                dec_pkt = in_pkt;
            end
        end
    end

    assign dec_pc          = dec_pkt.pc;
    assign dec_inst        = dec_pkt.inst;
    assign dec_epoch       = dec_pkt.epoch;
    assign dec_pred_taken  = dec_pkt.pred_taken;
    assign dec_pred_target = dec_pkt.pred_target;

    assign occupancy  = rst ? '0 : count;
    assign drop_count = rst ? '0 : drop_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            cur_epoch <= '0;
            drop_cnt  <= '0;
        end else begin
            if (drop && (drop_cnt != '1)) begin
                drop_cnt <= drop_cnt + DROP_CNT_W'(1);
            end
            if (redirect_valid) begin
                // Flush wins: everything buffered is wrong-path.
                head      <= '0;
                tail      <= '0;
                count     <= '0;
                cur_epoch <= cur_epoch + EPOCH_W'(1);
            end else begin
                if (push) begin
                    tail <= tail + AW'(1);
                end
                if (pop) begin
                    head <= head + AW'(1);
                end
                case ({push, pop})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: count <= count;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - scoreboard bench for fetch_queue with a queue-based reference model
module tb_fetch_queue;

    localparam int DEPTH = 4;
    localparam int EW    = 3;
    localparam int DW    = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [31:0]   in_pc = '0;
    logic [31:0]   in_inst = '0;
    logic [EW-1:0] in_epoch = '0;
    logic          in_pred_taken = 1'b0;
    logic [31:0]   in_pred_target = '0;
    logic          redirect_valid = 1'b0;
    logic          dec_valid;
    logic          dec_ready = 1'b0;
    logic [31:0]   dec_pc;
    logic [31:0]   dec_inst;
    logic [EW-1:0] dec_epoch;
    logic          dec_pred_taken;
    logic [31:0]   dec_pred_target;
    logic [$clog2(DEPTH):0] occupancy;
    logic [DW-1:0] drop_count;

    always #5 clk = ~clk;

    fetch_queue #(.DEPTH(DEPTH), .EPOCH_W(EW), .DROP_CNT_W(DW)) dut (
        .clk             (clk),
        .rst             (rst),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_pc           (in_pc),
        .in_inst         (in_inst),
        .in_epoch        (in_epoch),
        .in_pred_taken   (in_pred_taken),
        .in_pred_target  (in_pred_target),
        .redirect_valid  (redirect_valid),
        .dec_valid       (dec_valid),
        .dec_ready       (dec_ready),
        .dec_pc          (dec_pc),
        .dec_inst        (dec_inst),
        .dec_epoch       (dec_epoch),
        .dec_pred_taken  (dec_pred_taken),
        .dec_pred_target (dec_pred_target),
        .occupancy       (occupancy),
        .drop_count      (drop_count)
    );

    typedef struct {
        logic [99:0] payload;
        int          tag;
    } ent_t;

    ent_t          exp_q[$];
    int            n_cmp = 0;
    int            n_bad = 0;
    int            cyc = 0;
    logic [EW-1:0] m_epoch = '0;
    logic [DW-1:0] m_drops = '0;
    bit            acc = 1'b0;

    task automatic chk(input string nm, input logic [99:0] act, input logic [99:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Reference model: the queue contents are exp_q; an entry becomes visible
    // to decode once its tag is older than the current cycle.
    task automatic model_eval();
        bit   stale;
        bit   exp_ready;
        ent_t e;
        acc = 1'b0;
        if (rst) begin
            chk("rst_in_ready", 100'(in_ready), 100'(0));
            chk("rst_occupancy", 100'(occupancy), 100'(0));
            chk("rst_drop_count", 100'(drop_count), 100'(0));
            exp_q.delete();
            m_epoch = '0;
            m_drops = '0;
            return;
        end
        stale     = in_valid && (in_epoch != m_epoch);
        exp_ready = redirect_valid || stale || (exp_q.size() < DEPTH);
        chk("in_ready", 100'(in_ready), 100'(exp_ready));
        chk("occupancy", 100'(occupancy), 100'(exp_q.size()));
        chk("drop_count", 100'(drop_count), 100'(m_drops));
        if (in_valid && exp_ready && (stale || redirect_valid) && (m_drops != '1))
            m_drops = m_drops + 1'b1;
        if (redirect_valid) begin
            exp_q.delete();
            m_epoch = m_epoch + 1'b1;
        end else if (in_valid && exp_ready && !stale) begin
            e.payload = {in_pc, in_inst, in_epoch, in_pred_taken, in_pred_target};
            e.tag     = cyc;
`ifdef FETCHQ_BYPASS_EN
            if (exp_q.size() == 0 && dec_ready) e.tag = cyc - 1;
`endif
            exp_q.push_back(e);
            acc = 1'b1;
        end
    endtask

    task automatic step(input bit iv, input logic [31:0] pc, input logic [EW-1:0] ep,
                        input bit dr, input bit rd, input bit rs);
        @(posedge clk);
        #1;
        rst            = rs;
        in_valid       = iv;
        in_pc          = pc;
        in_inst        = $urandom;
        in_epoch       = ep;
        in_pred_taken  = 1'($urandom);
        in_pred_target = $urandom;
        dec_ready      = dr;
        redirect_valid = rd;
        cyc++;
        #2;
        model_eval();
    endtask

    // Monitor: compares the decode side against the head of the scoreboard.
    always @(negedge clk) begin
        bit vis;
        bit ev;
        vis = (exp_q.size() > 0) && (exp_q[0].tag < cyc);
        ev  = !rst && !redirect_valid && vis;
        chk("dec_valid", 100'(dec_valid), 100'(ev));
        if (ev) begin
            chk("dec_payload", {dec_pc, dec_inst, dec_epoch, dec_pred_taken, dec_pred_target},
                exp_q[0].payload);
            if (dec_ready) void'(exp_q.pop_front());
        end else if (rst || (!redirect_valid && !vis)) begin
            chk("dec_zero", {dec_pc, dec_inst, dec_epoch, dec_pred_taken, dec_pred_target},
                100'(0));
        end
    end

    initial begin
        logic [31:0] p;
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);

        // Fill, then a fifth packet while full.
        for (int i = 0; i < 5; i++) step(1, 32'(i * 4), 0, 0, 0, 0);
        // Drain with a producer retrying until accepted.
        p = 32'h10;
        for (int i = 0; i < 8; i++) begin
            step(1, p, 0, 1, 0, 0);
            if (acc) p = p + 4;
        end

        // Redirect flush with three entries held.
        step(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) step(1, 32'h100 + 32'(i * 4), 0, 0, 0, 0);
        step(1, 32'h10, 0, 0, 1, 0);
        step(1, 32'h14, 0, 0, 0, 0);
        step(1, 32'h80, 1, 1, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, 0);

        // Epoch wrap after eight redirects.
        step(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 8; i++) step(0, 0, 0, 1, 1, 0);
        step(1, 32'h200, 0, 1, 0, 0);
        step(1, 32'h204, 7, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);

        // Reset mid-operation with five drops and two entries held.
        step(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) step(1, 32'h300, 3, 0, 0, 0);
        step(1, 32'h304, 0, 0, 0, 0);
        step(1, 32'h308, 0, 0, 0, 0);
        step(1, 32'h30c, 0, 1, 0, 1);
        step(1, 32'h310, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);

        // Empty queue, decode ready: bypass or one-cycle latency.
        step(0, 0, 0, 0, 0, 1);
        step(1, 32'h40, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        step(1, 32'h44, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);

        // Randomized traffic.
        for (int i = 0; i < 800; i++) begin
            logic [EW-1:0] ep;
            ep = ($urandom_range(0, 4) == 0) ? EW'($urandom) : m_epoch;
            step(1'($urandom_range(0, 3) != 0), $urandom & 32'hffff_fffc, ep,
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0),
                 1'($urandom_range(0, 99) == 0));
        end

        for (int i = 0; i < 8; i++) step(0, 0, 0, 1, 0, 0);
        @(posedge clk);
        #1;
        chk("drain_empty", 100'(exp_q.size()), 100'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
